// File: rtl/half_precision.sv
// half_precision: registered binary16 operand classifier with per-class
// saturating population counters. One sample per cycle, no backpressure.
//
// Handshake: in_valid qualifies f on the rising edge where it is high; the
// classification of that sample appears on the outputs one cycle later with
// out_valid=1. There is no ready signal, so every valid sample is accepted.
// When out_valid=0 the flags and sign still show the last accepted sample.

module half_precision #(
   parameter int N  = 16,
   parameter int CW = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [N-1:0]  f,
   input  logic          cnt_clear,
   output logic          out_valid,
   output logic          sign,
   output logic          snan,
   output logic          qnan,
   output logic          infinity,
   output logic          zero,
   output logic          subnormal,
   output logic          normal,
   output logic [CW-1:0] cnt_snan,
   output logic [CW-1:0] cnt_qnan,
   output logic [CW-1:0] cnt_inf,
   output logic [CW-1:0] cnt_zero,
   output logic [CW-1:0] cnt_sub,
   output logic [CW-1:0] cnt_norm
);

   // Class vector bit positions, shared by the flag register and counters.
   localparam int C_SNAN = 5;
   localparam int C_QNAN = 4;
   localparam int C_INF  = 3;
   localparam int C_ZERO = 2;
   localparam int C_SUB  = 1;
   localparam int C_NORM = 0;

   logic [4:0]    exp_f;
   logic [9:0]    man_f;
   logic [5:0]    cls;
   logic [5:0]    flags_q;
   logic          sign_q;
   logic          valid_q;
   logic [CW-1:0] cnt_q [6];

   assign exp_f = f[14:10];
   assign man_f = f[9:0];

   // Saturating increment with optional clear applied first, so a sample
   // arriving together with a clear is counted from zero.
   function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cur,
                                                input logic hit,
                                                input logic clr);
      logic [CW-1:0] base;
      base = clr ? '0 : cur;
      if (hit && (base != {CW{1'b1}})) begin
         return base + CW'(1);
      end
      return base;
   endfunction

   // One-hot classification of the incoming operand; sign bit is ignored.
   always_comb begin
      cls = '0;
      if (exp_f == 5'h1f) begin
         if (man_f == 10'd0)   cls[C_INF]  = 1'b1;
         else if (man_f[9])    cls[C_QNAN] = 1'b1;
         else                  cls[C_SNAN] = 1'b1;
      end else if (exp_f == 5'h00) begin
         if (man_f == 10'd0)   cls[C_ZERO] = 1'b1;
         else                  cls[C_SUB]  = 1'b1;
      end else begin
         cls[C_NORM] = 1'b1;
      end
   end

   // Flag/sign register: loads on accepted samples, holds across idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         sign_q  <= 1'b0;
         flags_q <= '0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            flags_q <= cls;
            sign_q  <= f[N-1];
         end
      end
   end

   // Per-class population counters; reset beats clear, clear beats holding.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 6; i++) begin
            cnt_q[i] <= next_count(cnt_q[i], in_valid && cls[i], cnt_clear);
         end
      end
   end

   assign out_valid = valid_q;
   assign sign      = sign_q;
   assign snan      = flags_q[C_SNAN];
   assign qnan      = flags_q[C_QNAN];
   assign infinity  = flags_q[C_INF];
   assign zero      = flags_q[C_ZERO];
   assign subnormal = flags_q[C_SUB];
   assign normal    = flags_q[C_NORM];
   assign cnt_snan  = cnt_q[C_SNAN];
   assign cnt_qnan  = cnt_q[C_QNAN];
   assign cnt_inf   = cnt_q[C_INF];
   assign cnt_zero  = cnt_q[C_ZERO];
   assign cnt_sub   = cnt_q[C_SUB];
   assign cnt_norm  = cnt_q[C_NORM];

endmodule

// File: tb/tb_half_precision.sv
// Testbench for half_precision: directed vector table, gap/clear/reset
// sequences, an exhaustive binary16 sweep, and counter saturation checked on
// a narrow-counter instance that shares the same stimulus.

module tb_half_precision;

   localparam int CW  = 17;
   localparam int SCW = 4;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic        in_valid;
   logic [15:0] f;
   logic        cnt_clear;

   logic          out_valid, sign, snan, qnan, infinity, zero, subnormal, normal;
   logic [CW-1:0] cnt_snan, cnt_qnan, cnt_inf, cnt_zero, cnt_sub, cnt_norm;

   logic           s_out_valid, s_sign, s_snan, s_qnan, s_inf, s_zero, s_sub, s_norm;
   logic [SCW-1:0] s_cnt_snan, s_cnt_qnan, s_cnt_inf, s_cnt_zero, s_cnt_sub, s_cnt_norm;

   half_precision #(.N(16), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .f(f), .cnt_clear(cnt_clear),
      .out_valid(out_valid), .sign(sign), .snan(snan), .qnan(qnan),
      .infinity(infinity), .zero(zero), .subnormal(subnormal), .normal(normal),
      .cnt_snan(cnt_snan), .cnt_qnan(cnt_qnan), .cnt_inf(cnt_inf),
      .cnt_zero(cnt_zero), .cnt_sub(cnt_sub), .cnt_norm(cnt_norm)
   );

   half_precision #(.N(16), .CW(SCW)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .f(f), .cnt_clear(cnt_clear),
      .out_valid(s_out_valid), .sign(s_sign), .snan(s_snan), .qnan(s_qnan),
      .infinity(s_inf), .zero(s_zero), .subnormal(s_sub), .normal(s_norm),
      .cnt_snan(s_cnt_snan), .cnt_qnan(s_cnt_qnan), .cnt_inf(s_cnt_inf),
      .cnt_zero(s_cnt_zero), .cnt_sub(s_cnt_sub), .cnt_norm(s_cnt_norm)
   );

   wire [5:0] dut_flags = {snan, qnan, infinity, zero, subnormal, normal};

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [5:0] exp_q[$];
   int exp_cnt[6];     // index 5=snan .. 0=normal

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference classifier written on magnitude ranges rather than fields.
   function automatic logic [5:0] model_cls(input logic [15:0] x);
      logic [14:0] mag;
      mag = x[14:0];
      if (mag >= 15'h7e00)      return 6'b010000;
      else if (mag > 15'h7c00)  return 6'b100000;
      else if (mag == 15'h7c00) return 6'b001000;
      else if (mag == 15'h0000) return 6'b000100;
      else if (mag < 15'h0400)  return 6'b000010;
      else                      return 6'b000001;
   endfunction

   task automatic model_count(input logic [5:0] c);
      for (int k = 0; k < 6; k++) if (c[k]) exp_cnt[k]++;
   endtask

   task automatic model_clear();
      for (int k = 0; k < 6; k++) exp_cnt[k] = 0;
   endtask

   task automatic check_counts(input string tag);
      check({tag, ".cnt_snan"}, 32'(cnt_snan), 32'(exp_cnt[5]));
      check({tag, ".cnt_qnan"}, 32'(cnt_qnan), 32'(exp_cnt[4]));
      check({tag, ".cnt_inf"},  32'(cnt_inf),  32'(exp_cnt[3]));
      check({tag, ".cnt_zero"}, 32'(cnt_zero), 32'(exp_cnt[2]));
      check({tag, ".cnt_sub"},  32'(cnt_sub),  32'(exp_cnt[1]));
      check({tag, ".cnt_norm"}, 32'(cnt_norm), 32'(exp_cnt[0]));
   endtask

   // ---------------- driver ----------------
   // Drive inputs, let one rising edge pass, then return 1ns later so the
   // caller samples registered outputs away from the edge.
   task automatic step(input logic v, input logic [15:0] x, input logic clr);
      in_valid  = v;
      f         = x;
      cnt_clear = clr;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      cnt_clear = 1'b0;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [15:0] f;
      logic [5:0]  flags;   // {snan,qnan,inf,zero,sub,norm}
      logic        sign;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [5:0] e;
      int gap;

      vecs[0] = '{16'h7C00, 6'b001000, 1'b0};
      vecs[1] = '{16'hFE01, 6'b010000, 1'b1};
      vecs[2] = '{16'h7C01, 6'b100000, 1'b0};
      vecs[3] = '{16'h8000, 6'b000100, 1'b1};
      vecs[4] = '{16'h0001, 6'b000010, 1'b0};
      vecs[5] = '{16'h3C00, 6'b000001, 1'b0};

      rst = 1'b1; in_valid = 1'b0; f = '0; cnt_clear = 1'b0;
      model_clear();

      // Reset then idle
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      rst = 1'b0;
      step(1'b0, 16'h0, 1'b0);
      check("reset.out_valid", 32'(out_valid), 0);
      check("reset.flags", 32'(dut_flags), 0);
      check("reset.sign", 32'(sign), 0);
      check_counts("reset");

      // Single samples from the table
      for (int i = 0; i < 6; i++) begin
         step(1'b1, vecs[i].f, 1'b0);
         model_count(vecs[i].flags);
         check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 1);
         check($sformatf("vec%0d.flags", i), 32'(dut_flags), 32'(vecs[i].flags));
         check($sformatf("vec%0d.sign", i), 32'(sign), 32'(vecs[i].sign));
      end
      check_counts("vecs");

      // Gap handling: idle cycles hold flags and counts
      for (int p = 0; p < 3; p++) begin
         step(1'b1, 16'h8001, 1'b0);
         model_count(6'b000010);
         check("gap.load_flags", 32'(dut_flags), 32'(6'b000010));
         gap = $urandom_range(1, 3);
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 16'h7C00, 1'b0);
            check("gap.out_valid", 32'(out_valid), 0);
            check("gap.flags_hold", 32'(dut_flags), 32'(6'b000010));
            check("gap.sign_hold", 32'(sign), 1);
         end
      end
      check_counts("gap");

      // Clear collides with a valid zero: only that sample survives
      step(1'b1, 16'h0000, 1'b1);
      model_clear();
      model_count(6'b000100);
      check_counts("clr_collide");
      check("clr_collide.flags", 32'(dut_flags), 32'(6'b000100));

      // Clear alone: counters zero, flags untouched
      step(1'b0, 16'h3C00, 1'b1);
      model_clear();
      check_counts("clr_only");
      check("clr_only.flags", 32'(dut_flags), 32'(6'b000100));

      // Saturation on the narrow instance: 20 normals, count stops at 15
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 16'h3C00, 1'b0);
         check($sformatf("sat.cnt_norm@%0d", k), 32'(s_cnt_norm), (k > 15) ? 15 : k);
      end
      exp_cnt[0] = 20;
      check_counts("sat_wide");
      step(1'b0, 16'h0, 1'b1);
      model_clear();

      // Exhaustive sweep, back to back
      for (int i = 0; i < 65536; i++) begin
         e = model_cls(16'(i));
         exp_q.push_back(e);
         model_count(e);
         step(1'b1, 16'(i), 1'b0);
         e = exp_q.pop_front();
         if (dut_flags !== e || out_valid !== 1'b1 || sign !== i[15]) begin
            check($sformatf("sweep.f=%04h", i), {25'b0, out_valid, dut_flags},
                  {25'b0, 1'b1, e});
         end else begin
            checks++;
         end
      end
      check("sweep.total", exp_cnt[0] + exp_cnt[1] + exp_cnt[2] + exp_cnt[3] +
            exp_cnt[4] + exp_cnt[5], 65536);
      check("sweep.cnt_snan", 32'(cnt_snan), 1022);
      check("sweep.cnt_qnan", 32'(cnt_qnan), 1024);
      check("sweep.cnt_inf",  32'(cnt_inf),  2);
      check("sweep.cnt_zero", 32'(cnt_zero), 2);
      check("sweep.cnt_sub",  32'(cnt_sub),  2046);
      check("sweep.cnt_norm", 32'(cnt_norm), 61440);
      check("sweep.sat_norm", 32'(s_cnt_norm), 15);
      check("sweep.sat_inf",  32'(s_cnt_inf),  2);
      check("sweep.sat_snan", 32'(s_cnt_snan), 15);

      // Mid-stream reset discards the sample on that edge
      step(1'b1, 16'h3C00, 1'b0);
      step(1'b1, 16'hBC00, 1'b0);
      rst = 1'b1;
      step(1'b1, 16'h7C00, 1'b0);
      rst = 1'b0;
      check("midrst.out_valid", 32'(out_valid), 0);
      check("midrst.flags", 32'(dut_flags), 0);
      check("midrst.sign", 32'(sign), 0);
      model_clear();
      check_counts("midrst");
      check("midrst.sat_norm", 32'(s_cnt_norm), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
